fifo_wr_arbiter: RTL and testbench

Round-robin burst arbiter that shares the single write port of the 8-bit synchronous FIFO between several producers. Each producer presents a request, data and a hold-style handshake. The arbiter picks one owner, streams that owner's beats into the FIFO while honouring `full`, then rotates ownership. It sits directly in front of the FIFO write side (`wr_en`/`wdata`/`full`); the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_rr_pick.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Brief    : Shared types and default sizing for the FIFO write-port arbiter.
// Revision : 1.0
// ============================================================================
package fifo_arb_pkg;

    localparam int unsigned c_N_REQ       = 4;
    localparam int unsigned c_DATA_W      = 8;   // must equal the FIFO wdata width
    localparam int unsigned c_MAX_BURST   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_pick
// Brief    : Combinational rotate-priority picker; first set req bit at or
//            above rr_ptr, wrapping past the top index.
// Revision : 1.0
// ============================================================================
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = c_N_REQ,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = rr_ptr;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
            w_cand = (w_cand == c_LAST_IDX) ? '0 : w_cand + IDX_W'(1);
        end
    end

endmodule : fifo_rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO write port between
//            N_REQ producers; up to MAX_BURST beats per grant.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ     = c_N_REQ,
    parameter  int unsigned DATA_W    = c_DATA_W,
    parameter  int unsigned MAX_BURST = c_MAX_BURST,
    localparam int unsigned IDX_W     = $clog2(N_REQ),
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wdata,
    input  logic                      fifo_full,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner
);

    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(N_REQ - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_xfer;
    logic             w_release;

    fifo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_xfer         = 1'b0;
        w_release      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt    = BURST;
                    w_owner_nxt    = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                // Back-pressure stalls the owner in place; only a dropped req releases it.
                w_xfer    = req[r_owner] & ~fifo_full;
                w_release = ~req[r_owner] | (w_xfer & (r_beat_cnt == c_LAST_BEAT));
                if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
                if (w_release) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = (r_owner == c_LAST_IDX) ? '0 : r_owner + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt        = '0;
        fifo_wdata = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_xfer && (r_owner == IDX_W'(i))) begin
                gnt[i]     = 1'b1;
                fifo_wdata = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fifo_wr_en = w_xfer;
    assign busy       = (r_state == BURST);
    assign owner      = r_owner;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed self-checking bench for fifo_wr_arbiter (4 producers,
//            8-bit data, bursts of 4).
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] c_DAT = 32'h4030_2010;

    fifo_wr_arbiter #(
        .N_REQ     (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check all outputs.
    task automatic cyc(input string tag, input logic [3:0] r, input logic f,
                       input logic [31:0] d, input logic [3:0] eg,
                       input logic [7:0] ew, input logic eb, input logic [1:0] eo);
        @(negedge clk);
        req       = r;
        fifo_full = f;
        req_data  = d;
        #1;
        chk({tag, "/gnt"},   32'(gnt),        32'(eg));
        chk({tag, "/wr_en"}, 32'(fifo_wr_en), 32'(|eg));
        chk({tag, "/wdata"}, 32'(fifo_wdata), 32'(ew));
        chk({tag, "/busy"},  32'(busy),       32'(eb));
        chk({tag, "/owner"}, 32'(owner),      32'(eo));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst/gnt",   32'(gnt),        32'h0);
        chk("rst/wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst/wdata", 32'(fifo_wdata), 32'h0);
        chk("rst/busy",  32'(busy),       32'h0);
        chk("rst/owner", 32'(owner),      32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Single producer streaming A0..A5
        cyc("single_pick", 4'b0001, 1'b0, 32'h0000_00A0, 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc("single_b0",   4'b0001, 1'b0, 32'h0000_00A0, 4'b0001, 8'hA0, 1'b1, 2'd0);
        cyc("single_b1",   4'b0001, 1'b0, 32'h0000_00A1, 4'b0001, 8'hA1, 1'b1, 2'd0);
        cyc("single_b2",   4'b0001, 1'b0, 32'h0000_00A2, 4'b0001, 8'hA2, 1'b1, 2'd0);
        cyc("single_b3",   4'b0001, 1'b0, 32'h0000_00A3, 4'b0001, 8'hA3, 1'b1, 2'd0);
        cyc("single_bub",  4'b0001, 1'b0, 32'h0000_00A4, 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc("single_b4",   4'b0001, 1'b0, 32'h0000_00A4, 4'b0001, 8'hA4, 1'b1, 2'd0);
        cyc("single_b5",   4'b0001, 1'b0, 32'h0000_00A5, 4'b0001, 8'hA5, 1'b1, 2'd0);
        cyc("single_rel",  4'b0000, 1'b0, 32'h0000_00A5, 4'b0000, 8'h00, 1'b1, 2'd0);
        cyc("single_idle", 4'b0000, 1'b0, 32'h0000_00A5, 4'b0000, 8'h00, 1'b0, 2'd0);

        // Round robin with all producers requesting: owners 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 5; k++) begin
            int o;
            int prev;
            o    = k % 4;
            prev = (k == 0) ? 0 : (k - 1) % 4;
            cyc($sformatf("rr%0d_bub", k), 4'b1111, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b0, 2'(prev));
            for (int b = 0; b < 4; b++) begin
                cyc($sformatf("rr%0d_b%0d", k, b), 4'b1111, 1'b0, c_DAT,
                    4'(1 << o), 8'((o + 1) * 16), 1'b1, 2'(o));
            end
        end

        // Full back-pressure on owner 2 after two beats
        cyc("full_pick", 4'b0100, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc("full_b0",   4'b0100, 1'b0, c_DAT, 4'b0100, 8'h30, 1'b1, 2'd2);
        cyc("full_b1",   4'b0100, 1'b0, c_DAT, 4'b0100, 8'h30, 1'b1, 2'd2);
        for (int s = 0; s < 5; s++) begin
            cyc($sformatf("full_stall%0d", s), 4'b0100, 1'b1, c_DAT, 4'b0000, 8'h00, 1'b1, 2'd2);
        end
        cyc("full_b2",   4'b0100, 1'b0, c_DAT, 4'b0100, 8'h30, 1'b1, 2'd2);
        cyc("full_b3",   4'b0100, 1'b0, c_DAT, 4'b0100, 8'h30, 1'b1, 2'd2);
        cyc("full_idle", 4'b1000, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b0, 2'd2);

        // Early release by owner 3 and pointer wrap to 0
        cyc("wrap_b0",   4'b1011, 1'b0, c_DAT, 4'b1000, 8'h40, 1'b1, 2'd3);
        cyc("wrap_rel",  4'b0011, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b1, 2'd3);
        cyc("wrap_idle", 4'b0011, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b0, 2'd3);
        cyc("wrap_own0", 4'b0011, 1'b0, c_DAT, 4'b0001, 8'h10, 1'b1, 2'd0);

        // Asynchronous reset during an owner-1 beat
        cyc("mrst_rel",  4'b0010, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b1, 2'd0);
        cyc("mrst_idle", 4'b0010, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc("mrst_b0",   4'b0010, 1'b0, c_DAT, 4'b0010, 8'h20, 1'b1, 2'd1);
        @(negedge clk);
        req = 4'b0010;
        #1;
        chk("mrst_pre/gnt", 32'(gnt), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_in/gnt",   32'(gnt),        32'h0);
        chk("mrst_in/wr_en", 32'(fifo_wr_en), 32'h0);
        chk("mrst_in/wdata", 32'(fifo_wdata), 32'h0);
        chk("mrst_in/busy",  32'(busy),       32'h0);
        chk("mrst_in/owner", 32'(owner),      32'h0);
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        cyc("mrst_pick", 4'b1111, 1'b0, c_DAT, 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc("mrst_own0", 4'b1111, 1'b0, c_DAT, 4'b0001, 8'h10, 1'b1, 2'd0);

        // Non-owners toggling while owner 0 finishes its burst
        cyc("iso_b1",   4'b1111, 1'b0, 32'h4030_20B1, 4'b0001, 8'hB1, 1'b1, 2'd0);
        cyc("iso_b2",   4'b0101, 1'b0, 32'h4030_20B2, 4'b0001, 8'hB2, 1'b1, 2'd0);
        cyc("iso_b3",   4'b1011, 1'b0, 32'h4030_20B3, 4'b0001, 8'hB3, 1'b1, 2'd0);
        cyc("iso_idle", 4'b1110, 1'b0, c_DAT,         4'b0000, 8'h00, 1'b0, 2'd0);
        cyc("iso_own1", 4'b1110, 1'b0, c_DAT,         4'b0010, 8'h20, 1'b1, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
